kmeans_mem_sched: RTL
=====================

KMEANS_MEM_SCHED -- requirements
Module: kmeans_mem_sched

Interface
REQ-001 Parameter DW, 16, sample/data word width.
REQ-002 Parameter AW, 12, sample memory address width (capacity 4096 samples).
REQ-003 Parameter MAX_K, 4, maximum cluster count.
REQ-004 Parameter MAX_ITER, 16, iteration limit before forced output.
REQ-005 clk  in  1  single clock; all logic on rising edge.
REQ-006 rst_n  in  1  reset, asynchronous assert, active-low.
REQ-007 in_valid  in  1  input word qualifier.
REQ-008 in_data  in  DW  header words (K, then N), then samples.
REQ-009 mem_wen  out  1  sample SRAM write enable.
REQ-010 mem_addr  out  AW  sample SRAM address, shared by read and write.
REQ-011 mem_wdata  out  DW  SRAM write data.
REQ-012 mem_rdata  in  DW  SRAM read data, valid one cycle after address.
REQ-013 dp_valid / dp_data[DW] / dp_last  out  sample stream to distance datapath; dp_last marks sample N-1.
REQ-014 dp_ready  in  1  datapath accepts sample when dp_valid&dp_ready.
REQ-015 dp_done / dp_conv  in  1 / 1  datapath end-of-iteration pulse; dp_conv is the converged flag sampled with dp_done.
REQ-016 cen_idx  out  2  centroid select to datapath; cen_data  in  DW  combinational centroid value.
REQ-017 busy  out  1  high in any state other than IDLE.
REQ-018 out_valid / out_data[DW]  out  centroid result stream.

Function
REQ-019 States: IDLE, HDR_N, LOAD, STREAM, WAIT_DP, OUT.
REQ-020 IDLE: in_valid=1 captures K=in_data; K=0 or K>MAX_K is clamped to MAX_K; go HDR_N.
REQ-021 HDR_N: next in_valid=1 word captures N; N=0 or N>4096 is clamped to 4096; go LOAD with write pointer 0.
REQ-022 LOAD: each in_valid=1 cycle drives mem_wen=1, mem_addr=ptr, mem_wdata=in_data, same cycle (combinational from registered ptr); ptr increments; in_valid gaps allowed, nothing written on gaps.
REQ-023 LOAD -> STREAM on the cycle the N-th sample is written; iteration counter cleared to 0.
REQ-024 STREAM: reads addresses 0..N-1 in order; each sample presented exactly once on dp_data; dp_valid held with stable dp_data/dp_last until accepted.
REQ-025 STREAM throughput: one sample per cycle while dp_ready=1 after initial one-cycle read latency; dp_ready=0 for any duration loses and duplicates nothing.
REQ-026 mem_wen=0 in every state except LOAD.
REQ-027 STREAM -> WAIT_DP on acceptance of the dp_last sample; dp_valid low in WAIT_DP.
REQ-028 WAIT_DP on dp_done=1: if dp_conv=1 or iteration counter = MAX_ITER-1, go OUT; else increment counter and re-enter STREAM from address 0 without reloading.
REQ-029 dp_done outside WAIT_DP is ignored.
REQ-030 OUT: K consecutive cycles, out_valid=1, cen_idx=0..K-1, out_data=cen_data; then IDLE.
REQ-031 out_valid=0 in every state except OUT; out_data=0 when out_valid=0.
REQ-032 in_valid in STREAM, WAIT_DP, OUT ignored; no header re-capture until IDLE.
REQ-033 Pointer and address arithmetic is unsigned AW+1 bits internally; N=4096 must reach address 4095 without wrap to 0 before LOAD/STREAM completes.

Reset
REQ-034 rst_n=0 forces, asynchronously: state IDLE, pointers/iteration counter 0, K=MAX_K, N=4096, and all outputs (mem_wen, mem_addr, mem_wdata, dp_valid, dp_data, dp_last, cen_idx, busy, out_valid, out_data) to 0.
REQ-035 Reset mid-LOAD or mid-STREAM abandons the job; after release the block waits for a new header in IDLE; SRAM content is not cleared.

Verification
REQ-036 Header K=2, N=4, samples 10,20,30,40, dp_ready=1, dp_done+dp_conv=1 after last -> writes addr 0..3; dp_data 10,20,30,40 with dp_last on 40; out_valid 2 cycles, cen_idx 0,1.
REQ-037 Same load, dp_ready toggled 1,0,0,1,0,1... -> dp_data sequence exactly 10,20,30,40, no repeat or skip, dp_valid never drops before acceptance.
REQ-038 dp_conv=0 on every dp_done, MAX_ITER=16 -> exactly 16 STREAM passes of N samples, then OUT.
REQ-039 Header K=0, N=0 -> K=4, N=4096; all 4096 samples written to addr 0..4095, last stream sample flagged dp_last at addr 4095.
REQ-040 rst_n pulsed low during STREAM sample 2 -> all outputs 0 immediately; new header K=1, N=1, sample 7 -> dp_data 7 with dp_last, one out_valid cycle.
REQ-041 in_valid pulses during STREAM and dp_done pulses during LOAD -> no SRAM write, no state change from either.

Source files
------------

// File: rtl/kmeans_mem_sched.sv
// kmeans_mem_sched: job scheduler for a k-means engine.
// It captures the header (K, then N) and writes N samples into the sample SRAM.
// It then streams the samples to the distance datapath once per iteration until
// the datapath reports convergence or the iteration limit is reached. Finally it
// emits the K centroids.
// Ports:
//   clk, rst_n                 clock, async active-low reset
//   in_valid, in_data          header words then samples
//   mem_wen/addr/wdata/rdata   sample SRAM (1-cycle read latency)
//   dp_valid/data/last, dp_ready  sample stream to datapath
//   dp_done, dp_conv           end-of-iteration pulse and converged flag
//   cen_idx, cen_data          centroid select / value
//   busy                       any state other than IDLE
//   out_valid, out_data        centroid result stream
module kmeans_mem_sched #(
    parameter int unsigned DW       = 16,
    parameter int unsigned AW       = 12,
    parameter int unsigned MAX_K    = 4,
    parameter int unsigned MAX_ITER = 16
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    input  logic [DW-1:0] in_data,
    output logic          mem_wen,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    output logic          dp_valid,
    output logic [DW-1:0] dp_data,
    output logic          dp_last,
    input  logic          dp_ready,
    input  logic          dp_done,
    input  logic          dp_conv,
    output logic [1:0]    cen_idx,
    input  logic [DW-1:0] cen_data,
    output logic          busy,
    output logic          out_valid,
    output logic [DW-1:0] out_data
);

    localparam int unsigned PW = AW + 1;
    localparam int unsigned KW = $clog2(MAX_K + 1);
    localparam int unsigned IW = (MAX_ITER > 1) ? $clog2(MAX_ITER) : 1;
    localparam int unsigned CW = (DW > PW) ? DW : PW;
    localparam logic [PW-1:0] N_MAX     = PW'(2 ** AW);
    localparam logic [KW-1:0] K_MAX     = KW'(MAX_K);
    localparam logic [IW-1:0] ITER_LAST = IW'(MAX_ITER - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_HDR_N, S_LOAD, S_STREAM, S_WAIT_DP, S_OUT
    } state_t;

    state_t        state, state_nxt;
    logic [KW-1:0] k_reg;
    logic [PW-1:0] n_reg;
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [IW-1:0] iter;
    logic [KW-1:0] out_cnt;

    // read pipeline: one read in flight plus a one-entry skid behind dp_data
    logic          pend;
    logic          pend_last;
    logic          sk_valid;
    logic [DW-1:0] sk_data;
    logic          sk_last;

    logic [CW-1:0] in_wide;
    logic [KW-1:0] k_hdr_c;
    logic [PW-1:0] n_hdr_c;
    logic          load_last_c;
    logic          accept_c;
    logic          stream_done_c;
    logic          stop_c;
    logic          out_last_c;
    logic [1:0]    stored_c;
    logic          issue_c;

    // header clamping and shared event decode
    always_comb begin
        in_wide       = CW'(in_data);
        k_hdr_c       = (in_wide == '0 || in_wide > CW'(MAX_K)) ? K_MAX : KW'(in_data);
        n_hdr_c       = (in_wide == '0 || in_wide > CW'(2 ** AW)) ? N_MAX : PW'(in_data);
        load_last_c   = in_valid && (wr_ptr == n_reg - PW'(1));
        accept_c      = dp_valid && dp_ready;
        stream_done_c = accept_c && dp_last;
        stop_c        = dp_conv || (iter == ITER_LAST);
        out_last_c    = (out_cnt == k_reg - KW'(1));
        // entries held next cycle excluding a new issue; issue only if one slot stays free
        stored_c      = 2'(dp_valid) + 2'(sk_valid) + 2'(pend) - 2'(accept_c);
        issue_c       = (state == S_STREAM) && (rd_ptr < n_reg) && (stored_c <= 2'd1);
    end

    // state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_nxt;
    end

    // next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:    if (in_valid)      state_nxt = S_HDR_N;
            S_HDR_N:   if (in_valid)      state_nxt = S_LOAD;
            S_LOAD:    if (load_last_c)   state_nxt = S_STREAM;
            S_STREAM:  if (stream_done_c) state_nxt = S_WAIT_DP;
            S_WAIT_DP: if (dp_done)       state_nxt = stop_c ? S_OUT : S_STREAM;
            S_OUT:     if (out_last_c)    state_nxt = S_IDLE;
            default:                      state_nxt = S_IDLE;
        endcase
    end

    // outputs decoded from state and registered pointers
    always_comb begin
        mem_wen   = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        cen_idx   = '0;
        out_valid = 1'b0;
        out_data  = '0;
        busy      = (state != S_IDLE);
        case (state)
            S_LOAD: begin
                mem_wen   = in_valid;
                mem_addr  = wr_ptr[AW-1:0];
                mem_wdata = in_valid ? in_data : '0;
            end
            S_STREAM: mem_addr = rd_ptr[AW-1:0];
            S_OUT: begin
                out_valid = 1'b1;
                cen_idx   = 2'(out_cnt);
                out_data  = cen_data;
            end
            default: ;
        endcase
    end

    // job registers, pointers and the sample stream pipeline
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            k_reg     <= K_MAX;
            n_reg     <= N_MAX;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            iter      <= '0;
            out_cnt   <= '0;
            pend      <= 1'b0;
            pend_last <= 1'b0;
            sk_valid  <= 1'b0;
            sk_data   <= '0;
            sk_last   <= 1'b0;
            dp_valid  <= 1'b0;
            dp_data   <= '0;
            dp_last   <= 1'b0;
        end else begin
            case (state)
                S_IDLE: if (in_valid) k_reg <= k_hdr_c;
                S_HDR_N: if (in_valid) begin
                    n_reg  <= n_hdr_c;
                    wr_ptr <= '0;
                end
                S_LOAD: if (in_valid) begin
                    wr_ptr <= wr_ptr + PW'(1);
                    if (load_last_c) begin
                        iter     <= '0;
                        rd_ptr   <= '0;
                        pend     <= 1'b0;
                        sk_valid <= 1'b0;
                        dp_valid <= 1'b0;
                    end
                end
                S_STREAM: begin
                    pend      <= issue_c;
                    pend_last <= (rd_ptr == n_reg - PW'(1));
                    if (issue_c) rd_ptr <= rd_ptr + PW'(1);
                    if (!dp_valid || accept_c) begin
                        if (sk_valid) begin
                            dp_valid <= 1'b1;
                            dp_data  <= sk_data;
                            dp_last  <= sk_last;
                            sk_valid <= pend;
                            sk_data  <= mem_rdata;
                            sk_last  <= pend_last;
                        end else begin
                            dp_valid <= pend;
                            dp_data  <= pend ? mem_rdata : '0;
                            dp_last  <= pend && pend_last;
                        end
                    end else if (pend) begin
                        sk_valid <= 1'b1;
                        sk_data  <= mem_rdata;
                        sk_last  <= pend_last;
                    end
                end
                S_WAIT_DP: if (dp_done) begin
                    out_cnt <= '0;
                    if (!stop_c) begin
                        iter     <= iter + IW'(1);
                        rd_ptr   <= '0;
                        pend     <= 1'b0;
                        sk_valid <= 1'b0;
                    end
                end
                S_OUT: out_cnt <= out_cnt + KW'(1);
                default: ;
            endcase
        end
    end

endmodule
